// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, five-stage cycle sequencer and return-address stack
module pc_sequencer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_ready,
  input  logic [1:0]                     branch,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           brfl_control,
  input  logic                           flag_in,
  input  logic                           halt,
  input  logic [ADDR_WIDTH-1:0]          target,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [2:0]                     stage,
  output logic                           fetch_en,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           stack_err,
  output logic                           halted
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  typedef enum logic [2:0] {
    S_IFH = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } stage_t;

  stage_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc_next, pc_inc;
  logic [SPW-1:0]        sp_next;
  logic                  err_next, halted_next, push_en;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  // Low bits of sp address the RAM; sp-1 in those bits wraps the same way as sp itself.
  assign wr_idx      = sp[IW-1:0];
  assign rd_idx      = wr_idx - IW'(1);
  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign fetch_en    = (state == S_IFH) && !halted;
  assign stage       = state;

  // Stage register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IFH;
    else     state <= state_next;
  end

  // Stage stepping: MEM waits for the memory handshake, a halted core parks in IFH.
  always_comb begin
    state_next = state;
    case (state)
      S_IFH:   state_next = halted ? S_IFH : S_ID;
      S_ID:    state_next = S_EX;
      S_EX:    state_next = S_MEM;
      S_MEM:   state_next = mem_ready ? S_WB : S_MEM;
      S_WB:    state_next = S_IFH;
      default: state_next = S_IFH;
    endcase
  end

  // Control decode: controls only matter on the WB cycle; halt overrides every branch form.
  always_comb begin
    pc_next     = pc;
    sp_next     = sp;
    err_next    = stack_err;
    halted_next = halted;
    push_en     = 1'b0;
    if (state == S_WB && !halted) begin
      if (halt) begin
        halted_next = 1'b1;
      end else begin
        pc_next = pc_inc;
        case (branch)
          2'b01: begin
            if (push && !pop) begin
              if (!stack_full) begin
                push_en = 1'b1;
                sp_next = sp + SPW'(1);
                pc_next = target;
              end else begin
                err_next = 1'b1;
              end
            end else if (pop && !push) begin
              if (!stack_empty) begin
                sp_next = sp - SPW'(1);
                pc_next = stack_mem[rd_idx];
              end else begin
                err_next = 1'b1;
              end
            end
          end
          2'b10: begin
            if (!brfl_control || flag_in) pc_next = target;
          end
          default: pc_next = pc_inc;
        endcase
      end
    end
  end

  // Architectural registers; the stack RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      sp        <= '0;
      stack_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      pc        <= pc_next;
      sp        <= sp_next;
      stack_err <= err_next;
      halted    <= halted_next;
    end
  end

  // Return-address write on a successful call.
  always_ff @(posedge clk) begin
    if (push_en && !rst) stack_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, mem_ready, push, pop, brfl_control, flag_in, halt;
  logic [1:0]  branch;
  logic [15:0] target, pc;
  logic [2:0]  stage;
  logic        fetch_en, stack_full, stack_empty, stack_err, halted;
  logic [3:0]  sp;

  int errors = 0;
  int checks = 0;

  logic [15:0] mpc;
  logic [3:0]  msp;
  logic        merr, mhalt;
  logic [15:0] mstack [8];

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  sp;
    logic        err;
    logic        hlt;
  } exp_t;
  exp_t sb[$];

  pc_sequencer #(.ADDR_WIDTH(16), .STACK_DEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .branch(branch), .push(push), .pop(pop),
    .brfl_control(brfl_control), .flag_in(flag_in), .halt(halt), .target(target),
    .pc(pc), .stage(stage), .fetch_en(fetch_en), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    mpc = 16'h0000; msp = 4'd0; merr = 1'b0; mhalt = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, pc, mpc);
    check({tag, "_sp"}, sp, msp);
    check({tag, "_err"}, stack_err, merr);
    check({tag, "_halted"}, halted, mhalt);
    check({tag, "_full"}, stack_full, msp == 4'd8);
    check({tag, "_empty"}, stack_empty, msp == 4'd0);
  endtask

  // Controls that would change pc if they were sampled outside WB.
  task automatic drive_junk();
    branch = 2'b01; push = 1'b1; pop = 1'b0; halt = 1'b1;
    brfl_control = 1'b0; flag_in = 1'b1; target = 16'hbeef;
  endtask

  task automatic instr(input string tag, input logic [1:0] br, input logic pu, input logic po,
                       input logic bf, input logic fl, input logic hl, input logic [15:0] tg,
                       input int waits);
    exp_t e;
    check({tag, "_ifh_stage"}, stage, 3'd0);
    check({tag, "_ifh_fetch"}, fetch_en, 1'b1);
    check({tag, "_ifh_pc"}, pc, mpc);
    drive_junk();
    step(); check({tag, "_id_stage"}, stage, 3'd1); check({tag, "_id_fetch"}, fetch_en, 1'b0);
    step(); check({tag, "_ex_stage"}, stage, 3'd2); check({tag, "_ex_pc"}, pc, mpc);
    step(); check({tag, "_mem_stage"}, stage, 3'd3);
    if (waits > 0) mem_ready = 1'b0;
    for (int w = 0; w < waits; w++) begin
      step(); check({tag, "_mem_hold"}, stage, 3'd3);
    end
    mem_ready = 1'b1;
    step(); check({tag, "_wb_stage"}, stage, 3'd4); check({tag, "_wb_pc"}, pc, mpc);
    branch = br; push = pu; pop = po; brfl_control = bf; flag_in = fl; halt = hl; target = tg;
    if (hl) mhalt = 1'b1;
    else begin
      case (br)
        2'b01: begin
          if (pu && !po) begin
            if (msp < 4'd8) begin mstack[msp[2:0]] = mpc + 16'd1; msp = msp + 4'd1; mpc = tg; end
            else begin merr = 1'b1; mpc = mpc + 16'd1; end
          end else if (po && !pu) begin
            if (msp > 4'd0) begin msp = msp - 4'd1; mpc = mstack[msp[2:0]]; end
            else begin merr = 1'b1; mpc = mpc + 16'd1; end
          end else mpc = mpc + 16'd1;
        end
        2'b10: mpc = (!bf || fl) ? tg : mpc + 16'd1;
        default: mpc = mpc + 16'd1;
      endcase
    end
    sb.push_back('{pc: mpc, sp: msp, err: merr, hlt: mhalt});
    step();
    e = sb.pop_front();
    check({tag, "_pc"}, pc, e.pc);
    check({tag, "_sp"}, sp, e.sp);
    check({tag, "_err"}, stack_err, e.err);
    check({tag, "_halted"}, halted, e.hlt);
    check({tag, "_next_stage"}, stage, 3'd0);
    check({tag, "_fetch"}, fetch_en, !e.hlt);
    check({tag, "_full"}, stack_full, e.sp == 4'd8);
    check({tag, "_empty"}, stack_empty, e.sp == 4'd0);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; branch = 2'b00; push = 1'b0; pop = 1'b0;
    brfl_control = 1'b0; flag_in = 1'b0; halt = 1'b0; target = 16'h0000;
    model_reset();
    @(negedge clk);
    step();
    rst = 1'b0;
    check("reset_stage", stage, 3'd0);
    check("reset_fetch", fetch_en, 1'b1);
    check_state("reset");

    instr("seq0", 2'b00, 0, 0, 0, 0, 0, 16'h0, 0);
    instr("seq1", 2'b00, 0, 0, 0, 0, 0, 16'h0, 0);
    instr("seq2", 2'b00, 0, 0, 0, 0, 0, 16'h0, 0);
    instr("memwait", 2'b00, 0, 0, 0, 0, 0, 16'h0, 3);
    instr("seq4", 2'b00, 0, 0, 0, 0, 0, 16'h0, 0);

    instr("call40", 2'b01, 1, 0, 0, 0, 0, 16'h0040, 0);
    instr("ret40", 2'b01, 0, 1, 0, 0, 0, 16'h1234, 0);

    for (int i = 0; i < 9; i++)
      instr($sformatf("call%0d", i), 2'b01, 1, 0, 0, 0, 0, 16'h0100 + 16'(i * 16), (i == 4) ? 1 : 0);
    for (int i = 0; i < 9; i++)
      instr($sformatf("ret%0d", i), 2'b01, 0, 1, 0, 0, 0, 16'h0777, 0);

    instr("pushpop_both", 2'b01, 1, 1, 0, 0, 0, 16'h0abc, 0);
    instr("pushpop_none", 2'b01, 0, 0, 0, 0, 0, 16'h0abc, 0);
    instr("reserved11", 2'b11, 1, 0, 1, 1, 0, 16'h0abc, 0);
    instr("cond_flag0", 2'b10, 0, 0, 1, 0, 0, 16'h0020, 0);
    instr("cond_flag1", 2'b10, 0, 0, 1, 1, 0, 16'h0020, 0);
    instr("uncond_flag0", 2'b10, 0, 0, 0, 0, 0, 16'h0020, 2);
    instr("jump_ffff", 2'b10, 0, 0, 0, 0, 0, 16'hffff, 0);
    instr("wrap", 2'b00, 0, 0, 0, 0, 0, 16'h0, 0);
    instr("halt", 2'b10, 0, 0, 0, 0, 1, 16'h0055, 0);

    for (int i = 0; i < 20; i++) begin
      drive_junk();
      halt = 1'b0;
      step();
      check("halt_stage", stage, 3'd0);
      check("halt_fetch", fetch_en, 1'b0);
      check("halt_pc", pc, mpc);
      check("halt_flag", halted, 1'b1);
    end

    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    check_state("rst_after_halt");
    instr("call_pre_rst", 2'b01, 1, 0, 0, 0, 0, 16'h0030, 0);
    drive_junk();
    step(); step();
    check("mid_ex_stage", stage, 3'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("midrst_stage", stage, 3'd0);
    check("midrst_fetch", fetch_en, 1'b1);
    check_state("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequencer that drives instruction flow for the multi-cycle MUSA core.
- Holds the program counter and steps the five-stage cycle IFH->ID->EX->MEM->WB.
- Consumes the decoded control outputs (branch, push, pop, brfl_control, halt) and updates PC once per instruction.
- Contains the hardware return-address stack used by CALL/RET.

Parameters:
ADDR_WIDTH, 16, width of PC and branch target
STACK_DEPTH, 8, number of return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; synchronous, active-high
mem_ready  input  1  memory handshake; in MEM stage, sequencer holds until high
branch  input  2  00 sequential, 01 call/ret, 10 jump, 11 reserved
push  input  1  call: save return address (valid with branch=01)
pop  input  1  ret: restore return address (valid with branch=01)
brfl_control  input  1  jump is conditional on flag_in (valid with branch=10)
flag_in  input  1  ALU flag for conditional jump
halt  input  1  halt instruction decoded
target  input  ADDR_WIDTH  jump/call destination
pc  output  ADDR_WIDTH  current instruction address (registered)
stage  output  3  000 IFH, 001 ID, 010 EX, 011 MEM, 100 WB
fetch_en  output  1  instruction memory read strobe
sp  output  $clog2(STACK_DEPTH)+1  number of valid stack entries
stack_full  output  1  sp==STACK_DEPTH
stack_empty  output  1  sp==0
stack_err  output  1  sticky overflow/underflow flag
halted  output  1  core halted

Behaviour:
- Reset (rst=1 at any edge, including mid-instruction):
  - pc=RESET_PC, stage=IFH, sp=0, stack_err=0, halted=0.
  - Stack RAM contents are not cleared.
  - Outputs after reset: fetch_en=1, stack_empty=1, stack_full=0.
- Stage stepping, one cycle per stage: IFH->ID->EX->MEM->WB->IFH.
  - In MEM with mem_ready=0, stage holds; it advances on the first cycle with mem_ready=1.
  - Minimum 5 cycles per instruction; each cycle of mem_ready=0 adds one.
- fetch_en = (stage==IFH) && !halted; combinational from registered state.
- Control inputs are sampled only on the WB cycle edge. They are ignored in all other stages.
- PC update at WB edge (next-stage IFH sees the new pc); pc+1 is modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
  - halt=1: halted<=1, pc unchanged. Takes priority over all branch encodings. Stage goes to IFH and stays there until reset; no further updates.
  - branch=00: pc<=pc+1.
  - branch=01, push=1, pop=0:
    - if !stack_full: stack[sp]<=pc+1, sp<=sp+1, pc<=target.
    - else: stack_err<=1; no push, no jump; pc<=pc+1.
  - branch=01, pop=1, push=0:
    - if !stack_empty: pc<=stack[sp-1], sp<=sp-1.
    - else: stack_err<=1; pc<=pc+1.
  - branch=01 with push=pop, either both 0 or both 1: treated as sequential, pc<=pc+1, stack untouched.
  - branch=10, brfl_control=0: pc<=target.
  - branch=10, brfl_control=1: pc<=flag_in ? target : pc+1.
  - branch=11: reserved; pc<=pc+1.
- The return address pushed is pc+1 and wraps like pc.
- stack_err is sticky until reset; operation continues normally after an error.
- Stack is LIFO, with one push or one pop per instruction at most.

Test Plan:
- Reset then 3 instructions with branch=00, mem_ready=1 -> pc 0,1,2,3 at cycles 0,5,10,15; fetch_en high only in IFH; stage sequence 0,1,2,3,4 repeating.
- mem_ready=0 for 3 cycles during MEM -> stage stays at 011 for 4 cycles total; pc advances at cycle 8 instead of 5.
- At pc=5: call with target=0x40, push=1 -> pc=0x40, sp=1. Next instruction: pop=1 -> pc=6, sp=0, stack_empty=1, stack_err=0.
- Nine consecutive calls with STACK_DEPTH=8 -> after the 8th, stack_full=1. The 9th sets stack_err=1, pc=prev+1, sp stays 8. Then a pop with empty stack after draining 8 pops -> stack_err stays 1, pc+1.
- Conditional jump branch=10, brfl_control=1, target=0x20: flag_in=0 -> pc+1; flag_in=1 -> pc=0x20. Unconditional jump with brfl_control=0 -> pc=0x20 regardless of flag. pc=0xFFFF with branch=00 -> pc=0x0000.
- halt at WB -> halted=1, stage=IFH, fetch_en=0, pc frozen for 20 cycles. rst=1 asserted during EX of a later instruction -> next cycle pc=RESET_PC, stage=IFH, sp=0, halted=0.
